// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs in, pipeline stall/flush
// controls and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rd_e;
  logic             MemRead_e;
  logic             jump_e;
  logic             MemAccess_m;
  logic             dmem_ack;
  logic             cnt_clr;

  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic             flush_w;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // pipeline side
  modport master (
    output rs1_d, rs2_d, rd_e, MemRead_e, jump_e, MemAccess_m, dmem_ack, cnt_clr,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_m, flush_w,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  // hazard controller side
  modport slave (
    input  rs1_d, rs2_d, rd_e, MemRead_e, jump_e, MemAccess_m, dmem_ack, cnt_clr,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_m, flush_w,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait/abort, taken-branch flush,
// load-use stall, plus saturating stall/flush performance counters.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal flow; branch and load-use hazards resolved here
// MWAIT | data memory outstanding, wcnt counts waited cycles
// ABORT | single cycle: memory access timed out, bubble EX/MEM work
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;

  logic mem_wait;
  logic load_use;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic mem_timeout;

  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign mem_wait = hz.MemAccess_m & ~hz.dmem_ack & (state != ABORT);
  assign load_use = hz.MemRead_e & (hz.rd_e != 5'd0) &
                    ((hz.rd_e == hz.rs1_d) | (hz.rd_e == hz.rs2_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    flush_w     = 1'b0;
    mem_timeout = 1'b0;

    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt = MWAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MWAIT: begin
        if (hz.dmem_ack) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else if (mem_wait && (wcnt == WCNT_LAST)) begin
          state_nxt = ABORT;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      ABORT: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase

    // Fixed priority; a suppressed hazard is re-presented by the held EX stage.
    if (rst) begin
      stall_f = 1'b0;
    end else if (state == ABORT) begin
      mem_timeout = 1'b1;
      stall_f     = 1'b1;
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_m     = 1'b1;
    end else if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.jump_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hz.cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_d || flush_e) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_f     = stall_f;
  assign hz.stall_d     = stall_d;
  assign hz.stall_e     = stall_e;
  assign hz.stall_m     = stall_m;
  assign hz.flush_d     = flush_d;
  assign hz.flush_e     = flush_e;
  assign hz.flush_m     = flush_m;
  assign hz.flush_w     = flush_w;
  assign hz.mem_timeout = mem_timeout;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: short-timeout instance for the main
// checks, narrow-counter instance for saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  hz2 ();

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(255), .CNT_W(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .hz  (hz2.slave)
  );

  // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w,mem_timeout}
  localparam logic [8:0] O_IDLE  = 9'h000;
  localparam logic [8:0] O_LU    = 9'h188;
  localparam logic [8:0] O_MEMW  = 9'h1E2;
  localparam logic [8:0] O_ABORT = 9'h11D;
  localparam logic [8:0] O_JUMP  = 9'h018;

  logic [8:0] o1, o2;
  assign o1 = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
               hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w, hz.mem_timeout};
  assign o2 = {hz2.stall_f, hz2.stall_d, hz2.stall_e, hz2.stall_m,
               hz2.flush_d, hz2.flush_e, hz2.flush_m, hz2.flush_w, hz2.mem_timeout};

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic j, input logic ma, input logic ack,
                        input logic clr);
    hz.rs1_d        = rs1;  hz2.rs1_d       = rs1;
    hz.rs2_d        = rs2;  hz2.rs2_d       = rs2;
    hz.rd_e         = rd;   hz2.rd_e        = rd;
    hz.MemRead_e    = mr;   hz2.MemRead_e   = mr;
    hz.jump_e       = j;    hz2.jump_e      = j;
    hz.MemAccess_m  = ma;   hz2.MemAccess_m = ma;
    hz.dmem_ack     = ack;  hz2.dmem_ack    = ack;
    hz.cnt_clr      = clr;  hz2.cnt_clr     = clr;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // drive at the falling edge, sample 2 ns later, well clear of the rising edge
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(5'd3, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(); #2;
    check("rst_outs", 32'(o1), 32'(O_IDLE));

    cyc(); rst = 1'b0; idle(); #2;
    check("idle_outs", 32'(o1), 32'(O_IDLE));
    check("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // load-use on rs2
    cyc(); set_in(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    check("lu_rs2", 32'(o1), 32'(O_LU));
    cyc(); idle(); #2;
    check("lu_release", 32'(o1), 32'(O_IDLE));
    check("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);
    check("lu_flush_cnt", 32'(hz.flush_cnt), 32'd1);

    cyc(); set_in(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    check("lu_rs1", 32'(o1), 32'(O_LU));
    cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    check("lu_x0", 32'(o1), 32'(O_IDLE));
    cyc(); set_in(5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    check("no_load", 32'(o1), 32'(O_IDLE));

    // clear after 2 stalls / 2 flushes
    cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); idle(); #2;
    check("clr_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    check("clr_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // three wait cycles then ack
    for (int i = 0; i < 3; i++) begin
      cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #2;
      check("mwait_outs", 32'(o1), 32'(O_MEMW));
    end
    cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #2;
    check("mwait_ack", 32'(o1), 32'(O_IDLE));
    cyc(); idle(); #2;
    check("mwait_stall_cnt", 32'(hz.stall_cnt), 32'd3);
    check("mwait_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // timeout with TIMEOUT=4; ack during ABORT is ignored
    cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #2;
      check("tmo_wait", 32'(o1), 32'(O_MEMW));
    end
    cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #2;
    check("tmo_abort", 32'(o1), 32'(O_ABORT));
    cyc(); idle(); #2;
    check("tmo_after", 32'(o1), 32'(O_IDLE));
    check("tmo_stall_cnt", 32'(hz.stall_cnt), 32'd5);
    check("tmo_flush_cnt", 32'(hz.flush_cnt), 32'd1);

    // jump beats load-use
    cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); set_in(5'd4, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #2;
    check("jump_lu", 32'(o1), 32'(O_JUMP));
    cyc(); idle(); #2;
    check("jump_flush_cnt", 32'(hz.flush_cnt), 32'd1);
    check("jump_stall_cnt", 32'(hz.stall_cnt), 32'd0);

    // memory wait beats jump
    cyc(); set_in(5'd4, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); #2;
    check("mw_over_jump", 32'(o1), 32'(O_MEMW));
    cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #2;
    check("mw_over_jump_ack", 32'(o1), 32'(O_IDLE));

    // reset in the middle of a wait
    for (int i = 0; i < 2; i++) begin
      cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    cyc(); rst = 1'b1; #2;
    check("rst_in_mwait", 32'(o1), 32'(O_IDLE));
    cyc(); rst = 1'b0; idle(); #2;
    check("post_rst_outs", 32'(o1), 32'(O_IDLE));
    check("post_rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    check("post_rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // wait counter restarted: a full four-cycle wait precedes the abort
    for (int i = 0; i < 4; i++) begin
      cyc(); set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #2;
      check("post_rst_wait", 32'(o1), 32'(O_MEMW));
    end
    cyc(); #2;
    check("post_rst_abort", 32'(o1), 32'(O_ABORT));

    // clear wins over a simultaneous stall
    cyc(); set_in(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); #2;
    check("clr_lu_outs", 32'(o1), 32'(O_LU));
    cyc(); idle(); #2;
    check("clr_over_stall", 32'(hz.stall_cnt), 32'd0);
    check("clr_over_flush", 32'(hz.flush_cnt), 32'd0);

    // saturation on the 3-bit instance
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(); set_in(5'd6, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #2;
      check("sat_lu_outs", 32'(o2), 32'(O_LU));
    end
    cyc(); idle(); #2;
    check("sat_stall_cnt", 32'(hz2.stall_cnt), 32'd7);
    check("sat_flush_cnt", 32'(hz2.flush_cnt), 32'd7);
    check("wide_stall_cnt", 32'(hz.stall_cnt), 32'd9);
    check("wide_flush_cnt", 32'(hz.flush_cnt), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
